// File: rtl/dp_mem_pkg.sv
// Shared types and default widths for the dotProduct vector memory.
package dp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_MEM_SIZE   = 1 << DEF_ADDR_WIDTH;
  localparam int DEF_LEN_WIDTH  = DEF_ADDR_WIDTH + 1;

endpackage

// File: rtl/dp_vec_mem_if.sv
// Bus bundle for dp_vec_mem: write port, random read port, burst control and stream.
// slave = memory side, master = client side.
interface dp_vec_mem_if
  import dp_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) ();

  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  read_valid;
  logic                  burst_start;
  logic [ADDR_WIDTH-1:0] burst_base;
  logic [LEN_WIDTH-1:0]  burst_len;
  logic                  burst_busy;
  logic                  burst_err;
  logic                  burst_done;
  logic [DATA_WIDTH-1:0] stream_data;
  logic                  stream_valid;
  logic                  stream_last;
  logic                  stream_ready;

  modport slave (
    input  write_en, write_address, data_in, read_en, read_address,
           burst_start, burst_base, burst_len, stream_ready,
    output data_out, read_valid, burst_busy, burst_err, burst_done,
           stream_data, stream_valid, stream_last
  );

  modport master (
    output write_en, write_address, data_in, read_en, read_address,
           burst_start, burst_base, burst_len, stream_ready,
    input  data_out, read_valid, burst_busy, burst_err, burst_done,
           stream_data, stream_valid, stream_last
  );

endinterface

// File: rtl/dp_mem_array.sv
// Storage with one write port and two registered read ports (write-first bypass).
// Read latency 1 cycle; each read register holds its value when its enable is low.
module dp_mem_array
  import dp_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_SIZE   = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  a_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (a_en) a_data <= (we && (waddr == a_addr)) ? wdata : mem[a_addr];
      if (b_en) b_data <= (we && (waddr == b_addr)) ? wdata : mem[b_addr];
    end
  end

endmodule

// File: rtl/dp_vec_mem.sv
// Vector memory with random read port and wrap-around burst stream engine.
// Random read 1 cycle; first burst element 2 edges after start, then 1/clk; stream holds under !stream_ready.
module dp_vec_mem
  import dp_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_SIZE   = 2 ** ADDR_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic         clk,
  input logic         rst,
  dp_vec_mem_if.slave bus
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  stream_valid_q, stream_last_q;
  logic                  read_valid_q, err_q, done_q;
  logic                  start_ok, issue, final_issue, accept;

  dp_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.write_en),
    .waddr  (bus.write_address),
    .wdata  (bus.data_in),
    .a_en   (bus.read_en),
    .a_addr (bus.read_address),
    .a_data (bus.data_out),
    .b_en   (issue),
    .b_addr (addr),
    .b_data (bus.stream_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)    state_nxt = RUN;
      RUN:     if (final_issue) state_nxt = DRAIN;
      DRAIN:   if (accept)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ok    = (state == IDLE) && bus.burst_start && (bus.burst_len != '0);
    accept      = stream_valid_q && bus.stream_ready;
    issue       = (state == RUN) && (!stream_valid_q || bus.stream_ready);
    final_issue = issue && (remaining == LEN_WIDTH'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr           <= '0;
      remaining      <= '0;
      stream_valid_q <= 1'b0;
      stream_last_q  <= 1'b0;
      read_valid_q   <= 1'b0;
      err_q          <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      read_valid_q <= bus.read_en;
      err_q        <= bus.burst_start && (state != IDLE);
      done_q       <= (state == DRAIN) && accept;
      if (start_ok) begin
        addr      <= bus.burst_base;
        remaining <= bus.burst_len;
      end
      // Address is exactly ADDR_WIDTH bits, so the increment wraps at MEM_SIZE.
      if (issue) begin
        stream_valid_q <= 1'b1;
        stream_last_q  <= final_issue;
        addr           <= addr + ADDR_WIDTH'(1);
        remaining      <= remaining - LEN_WIDTH'(1);
      end else if (accept) begin
        stream_valid_q <= 1'b0;
        stream_last_q  <= 1'b0;
      end
    end
  end

  assign bus.read_valid   = read_valid_q;
  assign bus.stream_valid = stream_valid_q;
  assign bus.stream_last  = stream_last_q;
  assign bus.burst_busy   = (state != IDLE);
  assign bus.burst_err    = err_q;
  assign bus.burst_done   = done_q;

endmodule

// File: doc/dp_vec_mem.md
Name: dp_vec_mem

Overview:
Parametrised dual-read-port vector memory for the dotProduct datapath. It is the successor to the single-port mem1 storage. Beyond random-access write and read, it adds a burst read engine. The engine streams a contiguous, wrap-around block of elements to the MAC stage over a valid/ready handshake with backpressure. It adds write-first bypass and registered status/error pulses.

Parameters:
DATA_WIDTH, 8, element width in bits
ADDR_WIDTH, 6, address width
MEM_SIZE, 2**ADDR_WIDTH (64), number of entries; must equal 2**ADDR_WIDTH
LEN_WIDTH, ADDR_WIDTH+1, burst length width (allows length = MEM_SIZE)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
write_en  in  1  write strobe
write_address  in  ADDR_WIDTH  write address
data_in  in  DATA_WIDTH  write data
read_en  in  1  random read strobe
read_address  in  ADDR_WIDTH  random read address
data_out  out  DATA_WIDTH  random read data
read_valid  out  1  data_out valid pulse
burst_start  in  1  start burst request
burst_base  in  ADDR_WIDTH  first burst address
burst_len  in  LEN_WIDTH  element count
burst_busy  out  1  engine active
burst_err  out  1  one-cycle pulse: start rejected
burst_done  out  1  one-cycle pulse: burst finished
stream_data  out  DATA_WIDTH  burst element
stream_valid  out  1  stream_data valid
stream_last  out  1  final element of burst
stream_ready  in  1  consumer accepts element

Behaviour:
- Clock is clk; reset is asynchronous and active-high on rst.
- Reset values: data_out=0, read_valid=0, stream_data=0, stream_valid=0, stream_last=0, burst_busy=0, burst_err=0, burst_done=0, FSM=IDLE.
- Array contents are not reset; bench treats them as unknown until written.
- Write: mem[write_address] <= data_in at the clock edge when write_en=1.
- Random read: 1-cycle latency. At the edge with read_en=1, data_out <= mem[read_address] and read_valid=1 for one cycle. data_out holds its value otherwise.
- Bypass (write-first): a same-cycle write to the same address returns data_in. This applies to both the random port and the burst issue.
- Random read and burst operate independently, with no arbitration between them.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN: burst_start=1 and burst_len!=0. Latch addr=burst_base and remaining=burst_len.
  - burst_start with burst_len=0 in IDLE: ignored, no pulses.
  - RUN issue condition: (!stream_valid || stream_ready). On issue: stream_data <= mem[addr] (with bypass), stream_valid<=1, addr<=addr+1 mod MEM_SIZE (wraps 63->0), remaining--. stream_last<=1 when remaining==1.
  - Issuing the last element -> DRAIN.
  - RUN with no issue and stream_valid && stream_ready: stream_valid<=0.
  - DRAIN: on stream_valid && stream_ready, clear stream_valid/stream_last -> IDLE. burst_done pulses the following cycle.
- Sustained throughput is 1 element/clk with stream_ready held high. The first element is valid 2 edges after burst_start (latch edge, issue edge).
- stream_data/stream_last are stable while stream_valid && !stream_ready.
- burst_busy = (state != IDLE).
- burst_start while busy: ignored, burst_err pulses next cycle, and the current burst is unaffected.
- A write during a burst to a not-yet-issued address is reflected in the stream. Already-issued elements are unchanged.
- Reset mid-burst: immediate abort, all outputs to reset values.

Decomposition:
- Package dp_mem_pkg:
  - state enum {IDLE, RUN, DRAIN}
  - width helper constants for the default DATA_WIDTH/ADDR_WIDTH
- One sub-module, dp_mem_array:
  - storage array and write port
  - two registered read ports with write-first bypass
  - parameters DATA_WIDTH/ADDR_WIDTH/MEM_SIZE
- The top level holds the burst FSM, counters and handshake logic.

Test Plan:
1. Write 0x11@0, 0x22@1; read_en ra=0, then ra=1 -> data_out 0x11 then 0x22, each with a read_valid pulse 1 cycle after the strobe.
2. Same-cycle write 0xA5@1 with read_en ra=1 -> data_out=0xA5 next cycle (bypass).
3. Fill mem[i]=i; burst_base=62, burst_len=4, stream_ready=1 -> stream 0x3E,0x3F,0x00,0x01 on consecutive cycles. stream_last is high on 0x01, burst_done pulses 1 cycle after, and burst_busy falls.
4. Same burst with stream_ready toggling 1,0,0,1,... -> no element dropped or duplicated, and stream_data is stable while stalled.
5. burst_start during an active burst -> burst_err pulse, original stream intact. burst_len=0 in IDLE -> no busy, no pulses.
6. Assert rst mid-burst (after 2 of 8 elements) -> stream_valid=0 and burst_busy=0 immediately. A new burst then runs correctly from the new base.
